// File: rtl/relu_maxpool2_stream.sv
// relu_maxpool2_stream: streaming ReLU followed by a 2x2 / stride-2 max-pool.
// Consumes one signed conv sample per valid_in in raster order and emits one
// saturated, non-negative pooled value per completed 2x2 window.
// Optional build macro RELU_MAXPOOL_SAT_FLAG_EN adds a sticky sat_flag output
// that records clipping within the current frame.
module relu_maxpool2_stream #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12,
  parameter int MAP_W = 8,
  parameter int MAP_H = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    valid_out,
  output logic signed [OUT_W-1:0] data_out,
`ifdef RELU_MAXPOOL_SAT_FLAG_EN
  output logic                    sat_flag,
`endif
  output logic                    frame_done
);

  // After ReLU the sign bit is always zero, so magnitudes are carried in IN_W-1 bits.
  localparam int RW   = IN_W - 1;
  localparam int CW   = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int HW   = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int LB_N = MAP_W / 2;
  localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [RW-1:0] MAX_OUT = RW'((64'd1 << (OUT_W - 1)) - 64'd1);

  // Unsigned maximum of two post-ReLU magnitudes.
  function automatic logic [RW-1:0] umax(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]  col_cnt_r;
  logic [HW-1:0]  row_cnt_r;
  logic [RW-1:0]  pair_r;
  logic [RW-1:0]  line_buf_r [LB_N];

  logic [RW-1:0]  relu_s;
  logic [RW-1:0]  hmax_s;
  logic [RW-1:0]  pooled_s;
  logic [LBW-1:0] lb_idx_s;
  logic           col_last_s;
  logic           row_last_s;
  logic           win_done_s;
  logic           sat_s;

  // Datapath: ReLU, horizontal/vertical maxima and window-completion decode.
  always_comb begin
    relu_s     = {RW{1'b0}};
    hmax_s     = {RW{1'b0}};
    pooled_s   = {RW{1'b0}};
    lb_idx_s   = LBW'(col_cnt_r >> 1);
    col_last_s = (col_cnt_r == CW'(MAP_W - 1));
    row_last_s = (row_cnt_r == HW'(MAP_H - 1));
    win_done_s = valid_in & col_cnt_r[0] & row_cnt_r[0];
    if (data_in[IN_W-1]) begin
      relu_s = {RW{1'b0}};
    end else begin
      relu_s = data_in[RW-1:0];
    end
    hmax_s   = umax(pair_r, relu_s);
    pooled_s = umax(line_buf_r[lb_idx_s], hmax_s);
    sat_s    = (pooled_s > MAX_OUT);
  end

  // Raster position counters; both advance only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_r <= {CW{1'b0}};
      row_cnt_r <= {HW{1'b0}};
    end else if (valid_in) begin
      if (col_last_s) begin
        col_cnt_r <= {CW{1'b0}};
        if (row_last_s) begin
          row_cnt_r <= {HW{1'b0}};
        end else begin
          row_cnt_r <= row_cnt_r + HW'(1);
        end
      end else begin
        col_cnt_r <= col_cnt_r + CW'(1);
      end
    end
  end

  // Even column: hold the rectified sample for the horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_r <= {RW{1'b0}};
    end else if (valid_in && !col_cnt_r[0]) begin
      pair_r <= relu_s;
    end
  end

  // Even row, odd column: park the horizontal max until the odd row arrives.
  // Reads happen only on odd rows, so an entry is never read and written together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LB_N; i++) begin
        line_buf_r[i] <= {RW{1'b0}};
      end
    end else if (valid_in && col_cnt_r[0] && !row_cnt_r[0]) begin
      line_buf_r[lb_idx_s] <= hmax_s;
    end
  end

  // Registered outputs: one strobe per completed window, data held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      data_out   <= {OUT_W{1'b0}};
      frame_done <= 1'b0;
    end else begin
      valid_out  <= win_done_s;
      frame_done <= win_done_s & col_last_s & row_last_s;
      if (win_done_s) begin
        data_out <= sat_s ? OUT_W'(MAX_OUT) : OUT_W'(pooled_s);
      end
    end
  end

`ifdef RELU_MAXPOOL_SAT_FLAG_EN
  // Sticky clip indicator; cleared by the first pixel of a frame, a clip in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (win_done_s && sat_s) begin
      sat_flag <= 1'b1;
    end else if (valid_in && (col_cnt_r == {CW{1'b0}}) && (row_cnt_r == {HW{1'b0}})) begin
      sat_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/relu_maxpool2_stream.md
Name: relu_maxpool2_stream

Overview:
- Streaming ReLU plus 2x2/stride-2 max-pool stage. Sits directly downstream of each conv2 calc lane and consumes its 14-bit signed conv result plus valid strobe.
- Takes one MAP_W x MAP_H feature map per frame in raster order (default 8x8). Emits a (MAP_W/2) x (MAP_H/2) pooled map (default 4x4) in raster order, saturated to OUT_W bits, for the flatten/FC stage.
- One instance per conv2 output channel.

Parameters:
- IN_W, 14, width of signed input sample (matches conv2 calc output).
- OUT_W, 12, width of signed pooled output. Values are always non-negative after ReLU.
- MAP_W, 8, input map width in pixels; must be even and >= 2.
- MAP_H, 8, input map height in pixels; must be even and >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- valid_in  in  1  input sample strobe; gaps between strobes are allowed.
- data_in  in  IN_W  signed conv result, sampled only when valid_in=1.
- valid_out  out  1  one-cycle strobe marking a pooled result.
- data_out  out  OUT_W  signed pooled value, range 0..2^(OUT_W-1)-1.
- frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - valid_out=0, data_out=0, frame_done=0.
  - col_cnt=0, row_cnt=0, pair register=0, line buffer contents=0.
  - Reset mid-frame discards all partial windows. The next valid_in after reset is treated as pixel (0,0).
- Counters:
  - col_cnt runs 0..MAP_W-1 and row_cnt runs 0..MAP_H-1. Both advance only on valid_in.
  - col_cnt wraps to 0 after MAP_W-1; at that point row_cnt increments.
  - row_cnt wraps to 0 after MAP_H-1 with col_cnt=MAP_W-1, i.e. the next frame begins with no idle cycle required.
- ReLU: r = (data_in < 0) ? 0 : data_in, kept at IN_W-1 unsigned bits.
- Horizontal pair:
  - Even col_cnt: r is stored in the pair register.
  - Odd col_cnt: hmax = max(pair register, r), computed combinationally.
- Vertical pair, using a line buffer of MAP_W/2 entries of IN_W-1 bits, indexed col_cnt>>1:
  - Even row_cnt, odd col_cnt: line_buf[col_cnt>>1] <= hmax. No output.
  - Odd row_cnt, odd col_cnt: pooled = max(line_buf[col_cnt>>1], hmax).
- Saturation: if pooled > 2^(OUT_W-1)-1, data_out is set to 2^(OUT_W-1)-1; otherwise data_out = pooled, zero-extended.
- Latency and output timing:
  - data_out and valid_out are registered, and appear 1 cycle after the valid_in that completes the window (odd row, odd col).
  - valid_out is 0 in all other cycles. data_out holds its last value while valid_out=0.
- frame_done: asserted in the same cycle as the valid_out for window (MAP_H/2-1, MAP_W/2-1).
- Output rate: exactly (MAP_W/2)*(MAP_H/2) valid_out pulses per frame. No backpressure is provided; the downstream stage must accept one result per cycle.
- Line buffer:
  - The read and write of a given entry never occur in the same cycle.
  - Entries are overwritten on each even row and are not cleared between frames; reset is the only clear.
- Gaps: idle cycles (valid_in=0) at any point leave all state unchanged.

Optional Feature:
- Macro: RELU_MAXPOOL_SAT_FLAG_EN.
- When defined:
  - Adds output port sat_flag (1 bit, reset 0).
  - sat_flag is a sticky bit, set in the cycle any pooled value is clipped.
  - It is cleared when the first valid_in of a new frame (row_cnt=0, col_cnt=0) is accepted.
  - If the clear and a saturation coincide, set wins.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Ramp frame: data_in = 0..63 raster, back-to-back.
  - Expect 16 outputs: 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63.
  - frame_done is set with 63.
  - Each valid_out occurs 1 cycle after the input pixels at odd row, odd col.
- All-negative frame: 64 samples of -100.
  - Expect 16 outputs of 0 and a single frame_done.
- Saturation: one window containing 8191 (max positive 14-bit), all other pixels 5.
  - That window outputs 2047; all other windows output 5.
  - With RELU_MAXPOOL_SAT_FLAG_EN, sat_flag goes to 1 and clears on the first pixel of the next frame.
- Gapped input: ramp frame with random 0-3 idle cycles between samples.
  - Output values are identical to the ramp case.
  - valid_out never fires during idle gaps except the cycle after a completing sample.
- Mid-frame reset: send 37 pixels, pulse rst for 1 cycle, then send a full ramp frame.
  - Outputs stay at 0 and valid_out stays at 0 during reset.
  - The following frame yields exactly the ramp results, with no stale line-buffer data.
- Back-to-back frames: two ramp frames with no gap, the second offset by +100.
  - Second frame outputs are 109..163, matching the first frame's pattern +100.
  - frame_done pulses twice.
